// File: rtl/marquee_rx.sv
// Receive-side decoder for the marquee word stream: rebuilds operands A/B from the
// concatenation word, re-derives OR/AND/XOR and reports mismatches per frame.
module marquee_rx #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [2*W-1:0]   indata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     outdataA,
    output logic [W-1:0]     outdataB,
    output logic [2:0]       err_mask,
    output logic             sync_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t          state_reg;
    logic [2*W-1:0]  r_or;
    logic [2*W-1:0]  r_and;
    logic [2*W-1:0]  r_xor;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic [2*W-1:0]  recv_word [3];
    logic [2*W-1:0]  exp_word  [3];
    logic [2:0]      mask_next;
    logic            accept;
    logic            cnt_sat;

    assign a_in = indata[2*W-1:W];
    assign b_in = indata[W-1:0];

    // Logic words are compared over the full 2W bits, so stray upper bits count as errors.
    assign recv_word[0] = r_or;
    assign recv_word[1] = r_and;
    assign recv_word[2] = r_xor;
    assign exp_word[0]  = {{W{1'b0}}, a_in | b_in};
    assign exp_word[1]  = {{W{1'b0}}, a_in & b_in};
    assign exp_word[2]  = {{W{1'b0}}, a_in ^ b_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cmp
            assign mask_next[gi] = (recv_word[gi] != exp_word[gi]);
        end
    endgenerate

    // Only stall the concat word when an unconsumed result would be overwritten.
    assign in_ready = !((state_reg == S3) && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign cnt_sat  = &err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S0;
            r_or      <= '0;
            r_and     <= '0;
            r_xor     <= '0;
            out_valid <= 1'b0;
            outdataA  <= '0;
            outdataB  <= '0;
            err_mask  <= '0;
            sync_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            sync_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_sof) begin
                    r_or      <= indata;
                    state_reg <= S1;
                    if (state_reg != S0) begin
                        sync_err <= 1'b1;
                    end
                end else begin
                    case (state_reg)
                        S0: sync_err <= 1'b1;
                        S1: begin
                            r_and     <= indata;
                            state_reg <= S2;
                        end
                        S2: begin
                            r_xor     <= indata;
                            state_reg <= S3;
                        end
                        S3: begin
                            outdataA  <= a_in;
                            outdataB  <= b_in;
                            err_mask  <= mask_next;
                            out_valid <= 1'b1;
                            state_reg <= S0;
                            if ((mask_next != 3'b000) && !cnt_sat) begin
                                err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                        default: state_reg <= S0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_marquee_rx.sv
// Scoreboard bench for marquee_rx: expected results are queued as frames are driven
// and popped by a monitor whenever a result is handed off downstream.
module tb_marquee_rx;

    localparam int W     = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [2*W-1:0]   indata;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     outdataA;
    logic [W-1:0]     outdataB;
    logic [2:0]       err_mask;
    logic             sync_err;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    marquee_rx #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sof   (in_sof),
        .indata   (indata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .outdataA (outdataA),
        .outdataB (outdataB),
        .err_mask (err_mask),
        .sync_err (sync_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Inputs only change on the falling edge, so sampling 2ns later sees the handshake
    // that the next rising edge will perform.
    always begin
        @(negedge clk);
        #2;
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got A=%0d B=%0d mask=%b, scoreboard empty",
                         outdataA, outdataB, err_mask);
            end else begin
                mon_e = sb.pop_front();
                if ({outdataA, outdataB, err_mask} !== {mon_e.a, mon_e.b, mon_e.mask}) begin
                    errors++;
                    $display("FAIL result: got A=%0d B=%0d mask=%b, expected A=%0d B=%0d mask=%b",
                             outdataA, outdataB, err_mask, mon_e.a, mon_e.b, mon_e.mask);
                end else begin
                    $display("result A=%0d B=%0d mask=%b err_cnt=%0d",
                             outdataA, outdataB, err_mask, err_cnt);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the word was accepted.
    task automatic send(input logic sof, input logic [2*W-1:0] data);
        int n;
        in_valid = 1'b1;
        in_sof   = sof;
        indata   = data;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic frame(input logic [2*W-1:0] w0, input logic [2*W-1:0] w1,
                         input logic [2*W-1:0] w2, input logic [2*W-1:0] w3);
        send(1'b1, w0);
        send(1'b0, w1);
        send(1'b0, w2);
        send(1'b0, w3);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        indata = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, outdataA, outdataB, err_mask, sync_err, err_cnt, in_ready} !==
            {1'b0, 3'd0, 3'd0, 3'b000, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b A=%0d B=%0d m=%b se=%b cnt=%0d rdy=%b, required 0/0/0/000/0/0/1",
                     out_valid, outdataA, outdataB, err_mask, sync_err, err_cnt, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean;
        out_ready = 1'b1;
        sb.push_back('{a: 3'd5, b: 3'd3, mask: 3'b000});
        frame(6'h07, 6'h01, 6'h06, 6'h2B);
        checks++;
        if ({out_valid, outdataA, outdataB, err_mask, err_cnt} !== {1'b1, 3'd5, 3'd3, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL clean_latency: got v=%b A=%0d B=%0d m=%b cnt=%0d, required 1/5/3/000/0",
                     out_valid, outdataA, outdataB, err_mask, err_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_clear: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_and_err;
        out_ready = 1'b1;
        sb.push_back('{a: 3'd5, b: 3'd3, mask: 3'b010});
        frame(6'h07, 6'h03, 6'h06, 6'h2B);
        checks++;
        if (err_mask !== 3'b010 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL and_err: got m=%b cnt=%0d, required 010/1", err_mask, err_cnt);
        end
        for (int i = 1; i < 300; i++) begin
            sb.push_back('{a: 3'd5, b: 3'd3, mask: 3'b010});
            frame(6'h07, 6'h03, 6'h06, 6'h2B);
            if (i == 254) begin
                checks++;
                if (err_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL cnt_reach_max: err_cnt=%0d, required 255", err_cnt);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_saturate: err_cnt=%0d, required 255", err_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_upper;
        out_ready = 1'b1;
        sb.push_back('{a: 3'd5, b: 3'd3, mask: 3'b001});
        frame(6'h0F, 6'h01, 6'h06, 6'h2B);
        checks++;
        if (err_mask !== 3'b001 || err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL upper_bits: got m=%b cnt=%0d, required 001/255", err_mask, err_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_framing;
        out_ready = 1'b1;
        send(1'b0, 6'h07);
        checks++;
        if (sync_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_sof: got se=%b v=%b, required 1/0", sync_err, out_valid);
        end
        @(negedge clk);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sync_pulse_width: sync_err=%b, required 0", sync_err);
        end
        send(1'b1, 6'h07);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sof_in_s0: sync_err=%b, required 0", sync_err);
        end
        send(1'b0, 6'h01);
        send(1'b1, 6'h07);
        checks++;
        if (sync_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL resync: got se=%b v=%b, required 1/0", sync_err, out_valid);
        end
        sb.push_back('{a: 3'd5, b: 3'd3, mask: 3'b000});
        send(1'b0, 6'h01);
        send(1'b0, 6'h06);
        send(1'b0, 6'h2B);
        checks++;
        if (out_valid !== 1'b1 || err_mask !== 3'b000) begin
            errors++;
            $display("FAIL resync_frame: got v=%b m=%b, required 1/000", out_valid, err_mask);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        sb.push_back('{a: 3'd5, b: 3'd3, mask: 3'b000});
        sb.push_back('{a: 3'd2, b: 3'd6, mask: 3'b000});
        frame(6'h07, 6'h01, 6'h06, 6'h2B);
        send(1'b1, 6'h06);
        send(1'b0, 6'h02);
        send(1'b0, 6'h04);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        indata   = 6'h16;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready, out_valid, outdataA, outdataB} !== {1'b0, 1'b1, 3'd5, 3'd3}) begin
                errors++;
                $display("FAIL backpressure_hold: got rdy=%b v=%b A=%0d B=%0d, required 0/1/5/3",
                         in_ready, out_valid, outdataA, outdataB);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, outdataA, outdataB} !== {1'b1, 3'd2, 3'd6}) begin
            errors++;
            $display("FAIL replace_result: got v=%b A=%0d B=%0d, required 1/2/6",
                     out_valid, outdataA, outdataB);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_midframe;
        out_ready = 1'b1;
        send(1'b1, 6'h07);
        send(1'b0, 6'h01);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b cnt=%0d se=%b, required 0/0/0",
                     out_valid, err_cnt, sync_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.push_back('{a: 3'd7, b: 3'd0, mask: 3'b000});
        send(1'b1, 6'h07);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL stale_frame: sync_err=%b, required 0", sync_err);
        end
        send(1'b0, 6'h00);
        send(1'b0, 6'h07);
        send(1'b0, 6'h38);
        checks++;
        if ({out_valid, outdataA, outdataB, err_mask, err_cnt} !== {1'b1, 3'd7, 3'd0, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL post_reset_frame: got v=%b A=%0d B=%0d m=%b cnt=%0d, required 1/7/0/000/0",
                     out_valid, outdataA, outdataB, err_mask, err_cnt);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_and_err();
        test_upper();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
